// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: queue entry layout and load opcode encodings
package issue_scheduler_pkg;
  localparam logic [3:0] OP_LOAD_LLI = 4'hE;
  localparam logic [3:0] OP_LOAD_LUI = 4'hF;
  typedef struct packed {
    logic [3:0]  op;
    logic        load;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/issue_scheduler_fifo.sv
// issue_scheduler_fifo: in-order instruction queue with flush; head reads zero when empty
module issue_scheduler_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order issue queue gated by a per-register busy scoreboard
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm,
  input  logic             in_load,
  input  logic [3:0]       in_op,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [4:0]       iss_rs1,
  output logic [4:0]       iss_rs2,
  output logic [4:0]       iss_rd,
  output logic [15:0]      iss_imm,
  output logic             iss_load,
  output logic [3:0]       iss_op,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             idle,
  output logic             ovf_err,
  output logic [15:0]      stall_cnt
);
  entry_t in_e, head;
  logic full, empty, blocked, pop;
  logic [NREGS-1:0] eff_busy;
  assign in_e = '{op: in_op, load: in_load, imm: in_imm, rd: in_rd, rs2: in_rs2, rs1: in_rs1};
  issue_scheduler_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid && in_ready), .pop(pop), .flush(flush),
    .din(in_e), .full(full), .empty(empty), .head(head)
  );
  assign in_ready = !full;
  // a retiring writeback frees its register in the same cycle it arrives
  assign eff_busy = busy & ~(wb_valid ? NREGS'(1) << wb_rd : '0);
  assign blocked = head.load ? eff_busy[head.rd]
                             : eff_busy[head.rs1] | eff_busy[head.rs2] | eff_busy[head.rd];
  assign iss_valid = !empty && !blocked && !flush;
  assign pop = iss_valid && iss_ready;
  assign {iss_op, iss_load, iss_imm, iss_rd, iss_rs2, iss_rs1} = head;
  assign idle = empty && busy == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= '0;
      ovf_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      busy <= eff_busy | (pop ? NREGS'(1) << head.rd : '0);
      if (in_valid && !in_ready) ovf_err <= 1'b1;
      if (!empty && blocked && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: vector table plus hand sequences, issue order checked by a scoreboard
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_load = 0, iss_ready = 0, wb_valid = 0, flush = 0;
  logic [4:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0, wb_rd = 0;
  logic [15:0] in_imm = 0;
  logic [3:0] in_op = 0;
  logic in_ready, iss_valid, iss_load, idle, ovf_err;
  logic [4:0] iss_rs1, iss_rs2, iss_rd;
  logic [15:0] iss_imm, stall_cnt;
  logic [3:0] iss_op;
  logic [31:0] busy;
  int n_checks = 0, n_fail = 0, n_issued = 0;
  entry_t exp_q[$];

  issue_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_load(in_load), .in_op(in_op),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_load(iss_load), .iss_op(iss_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy(busy), .idle(idle),
    .ovf_err(ovf_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // inputs are stable across the falling edge, so a handshake seen here completes on the next rise
  always @(negedge clk)
    if (!rst) exp_q.delete();
    else if (flush) exp_q.delete();
    else begin
      if (iss_valid && iss_ready) begin
        n_issued++;
        if (exp_q.size() == 0) chk("unexpected_issue", {iss_op, iss_load, iss_imm, iss_rd, iss_rs2, iss_rs1}, 64'hDEAD);
        else chk("issue_entry", {iss_op, iss_load, iss_imm, iss_rd, iss_rs2, iss_rs1}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back('{op: in_op, load: in_load, imm: in_imm, rd: in_rd, rs2: in_rs2, rs1: in_rs1});
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input int rd, input logic ld, input int op);
    in_valid = v;
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_rd = 5'(rd);
    in_load = ld;
    in_op = 4'(op);
    in_imm = 16'($urandom);
  endtask

  typedef struct {
    logic v, ld, ir, wv, exp_iv;
    int rs1, rs2, rd, op, wrd;
    logic [31:0] exp_busy;
    logic [15:0] exp_stall;
  } vec_t;

  function automatic vec_t mk(input int v, input int rs1, input int rs2, input int rd, input int ld,
                              input int op, input int ir, input int wv, input int wrd,
                              input int iv, input int bz, input int st);
    vec_t t;
    t.v = v[0]; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.ld = ld[0]; t.op = op;
    t.ir = ir[0]; t.wv = wv[0]; t.wrd = wrd; t.exp_iv = iv[0];
    t.exp_busy = 32'(bz); t.exp_stall = 16'(st);
    return t;
  endfunction

  vec_t tv[17];

  initial begin
    int base;
    tv[0]  = mk(1, 1, 2, 3, 0, 1, 1, 0, 0, 0, 'h0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h8, 0);
    tv[2]  = mk(1, 3, 0, 4, 0, 2, 1, 0, 0, 0, 'h8, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h8, 1);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h8, 2);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 'h10, 2);
    tv[6]  = mk(1, 0, 0, 3, 0, 1, 1, 0, 0, 0, 'h10, 2);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h18, 2);
    tv[8]  = mk(1, 3, 3, 5, 1, int'(OP_LOAD_LUI), 1, 0, 0, 0, 'h18, 2);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h38, 2);
    tv[10] = mk(1, 0, 0, 5, 1, int'(OP_LOAD_LLI), 1, 0, 0, 0, 'h38, 2);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h38, 3);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 'h38, 3);
    tv[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 'h30, 3);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 'h20, 3);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 'h0, 3);
    tv[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 'h0, 3);

    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_busy", busy, 0);
    chk("rst_iss_fields", {iss_op, iss_load, iss_imm, iss_rd, iss_rs2, iss_rs1}, 0);
    rst = 1;
    step();

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].ld, tv[i].op);
      iss_ready = tv[i].ir;
      wb_valid = tv[i].wv;
      wb_rd = 5'(tv[i].wrd);
      #1;
      chk($sformatf("vec%0d_iss_valid", i), iss_valid, tv[i].exp_iv);
      step();
      chk($sformatf("vec%0d_busy", i), busy, tv[i].exp_busy);
      chk($sformatf("vec%0d_stall", i), stall_cnt, tv[i].exp_stall);
      if (i == 1) chk("vec1_idle", idle, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    wb_valid = 0;
    chk("table_idle", idle, 1);

    iss_ready = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 10 + k, 0, 1);
      #1;
      chk($sformatf("ovf_in_ready%0d", k), in_ready, k < 4);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_err", ovf_err, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_hold_valid", iss_valid, 1);
    iss_ready = 1;
    #1;
    chk("full_pop_no_comb_ready", in_ready, 0);
    base = n_issued;
    repeat (6) step();
    chk("drain_count", n_issued - base, 4);
    chk("drain_sb_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 32'h3C00);
    for (int r = 10; r < 14; r++) begin
      wb_valid = 1;
      wb_rd = 5'(r);
      step();
    end
    wb_valid = 0;
    chk("clear_idle", idle, 1);

    drive(1, 0, 0, 7, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("r7_busy", busy, 32'h80);
    drive(1, 0, 0, 7, 0, 3);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("r7_blocked", iss_valid, 0);
    wb_valid = 1;
    wb_rd = 7;
    #1;
    chk("r7_wb_unblock", iss_valid, 1);
    step();
    wb_valid = 0;
    chk("r7_set_wins", busy, 32'h80);

    iss_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 20 + k, 0, 1);
      step();
    end
    drive(1, 0, 0, 23, 0, 1);
    flush = 1;
    #1;
    chk("flush_iss_valid", iss_valid, 0);
    step();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    iss_ready = 1;
    #1;
    chk("flush_empty", iss_valid, 0);
    chk("flush_fields", iss_rd, 0);
    chk("flush_busy_kept", busy, 32'h80);
    chk("flush_not_idle", idle, 0);
    drive(1, 0, 0, 24, 0, 5);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("post_flush_issue", iss_valid, 1);
    step();
    chk("post_flush_busy", busy, 32'h0100_0080);

    drive(1, 7, 0, 25, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (65540) step();
    chk("stall_sat", stall_cnt, 16'hFFFF);
    chk("stall_blocked", iss_valid, 0);
    step();
    chk("stall_sat_hold", stall_cnt, 16'hFFFF);

    #2 rst = 0;
    #1;
    chk("async_in_ready", in_ready, 1);
    chk("async_iss_valid", iss_valid, 0);
    chk("async_idle", idle, 1);
    chk("async_busy", busy, 0);
    chk("async_ovf", ovf_err, 0);
    chk("async_stall", stall_cnt, 0);
    chk("async_fields", {iss_op, iss_load, iss_imm, iss_rd, iss_rs2, iss_rs1}, 0);
    step();
    rst = 1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
